izh_spike_monitor: RTL and testbench



---
 rtl/izh_mon_pkg.sv | 21 ++
 rtl/izh_spike_monitor_if.sv | 17 +
 rtl/izh_spike_monitor_isi_fifo.sv | 61 ++++++
 rtl/izh_spike_monitor.sv | 111 +++++++++++
 tb/tb_izh_spike_monitor.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/izh_mon_pkg.sv
// Shared definitions for the Izhikevich spike monitor.
//   det_state_t : detector state encoding (ARMED / REFRACT)
//   V_ONE, TH_HI_DEF, TH_LO_DEF : voltage codes in the neuron's 2.6 fixed point
//   sat_inc()   : increment that sticks at a maximum value
package izh_mon_pkg;

    typedef logic [0:0] det_state_t;
    localparam det_state_t ARMED   = 1'b0;
    localparam det_state_t REFRACT = 1'b1;

    // 2.6 fixed point: 1.0 = 64
    localparam logic signed [7:0] V_ONE     = 8'sd64;
    localparam logic signed [7:0] TH_HI_DEF = 8'sd16;
    localparam logic signed [7:0] TH_LO_DEF = -8'sd24;

    // Callers zero-extend into 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/izh_spike_monitor_if.sv
// ISI stream from the spike monitor to its consumer.
//   isi_valid : head entry present (master -> slave)
//   isi_data  : head entry value, 0 when empty (master -> slave)
//   isi_ready : consumer accepts the head entry (slave -> master)
// Handshake: a transfer happens on a rising clk edge where isi_valid && isi_ready;
// isi_data is stable while isi_valid is high and not yet accepted; isi_valid never
// depends combinationally on isi_ready.
interface izh_isi_if #(
    parameter int WIDTH = 16
);
    logic             isi_valid;
    logic             isi_ready;
    logic [WIDTH-1:0] isi_data;

    modport master (output isi_valid, output isi_data, input isi_ready);
    modport slave  (input isi_valid, input isi_data, output isi_ready);
endinterface

// File: rtl/izh_spike_monitor_isi_fifo.sv
// First-word-fall-through FIFO holding inter-spike intervals.
//   clk, rst_n      : clock, synchronous active-low reset
//   clr             : synchronous flush, wins over push and pop
//   push, push_data : write request and value
//   pop             : remove head (ignored while empty)
//   full, empty     : occupancy flags
//   drop            : push refused because full with no same-cycle pop
//   head            : head value, forced to 0 while empty
module isi_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign drop      = push && full && !w_pop_ok;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clr && w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/izh_spike_monitor.sv
// Spike detector and inter-spike-interval monitor for an Izhikevich neuron.
//   clk, rst_n   : clock, synchronous active-low reset
//   sample_en    : v_in holds a new neuron sample this cycle
//   v_in         : signed 2.6 membrane voltage code
//   clr          : synchronous clear of statistics (detector state kept)
//   spike_pulse  : one-cycle pulse after each spike sample
//   isi          : ISI stream (valid/ready), FWFT buffered
//   overflow     : sticky, an ISI was dropped on a full buffer
//   spike_count  : saturating spike count since reset or clr
//   dbg_state    : detector state for observation
module izh_spike_monitor
    import izh_mon_pkg::*;
#(
    parameter logic signed [7:0] TH_HI      = TH_HI_DEF,
    parameter logic signed [7:0] TH_LO      = TH_LO_DEF,
    parameter int                ISI_W      = 16,
    parameter int                CNT_W      = 16,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic signed [7:0] v_in,
    input  logic              clr,
    output logic              spike_pulse,
    izh_isi_if.master         isi,
    output logic              overflow,
    output logic [CNT_W-1:0]  spike_count,
    output det_state_t        dbg_state
);
    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    det_state_t       r_state;
    logic [ISI_W-1:0] r_isi_cnt;
    logic             r_have_prev;
    logic             r_spike_pulse;
    logic             r_overflow;
    logic [CNT_W-1:0] r_spike_count;

    logic             w_spike;
    logic             w_rearm;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [ISI_W-1:0] w_isi_next;

    // Hysteresis: fire only from ARMED, re-arm only from REFRACT.
    assign w_spike    = sample_en && (r_state == ARMED) && (v_in >= TH_HI);
    assign w_rearm    = sample_en && (r_state == REFRACT) && (v_in <= TH_LO);
    // The spike sample itself is counted, so spikes k and k+10 give 10.
    assign w_isi_next = ISI_W'(sat_inc(32'(r_isi_cnt), 32'(ISI_MAX)));
    // The first spike after reset/clr has no predecessor and pushes nothing.
    assign w_push     = w_spike && r_have_prev && !clr;
    assign w_pop      = !w_empty && isi.isi_ready && !clr;

    isi_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (w_push),
        .push_data (w_isi_next),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .drop      (w_drop),
        .head      (isi.isi_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ARMED;
            r_isi_cnt     <= '0;
            r_have_prev   <= 1'b0;
            r_spike_pulse <= 1'b0;
            r_overflow    <= 1'b0;
            r_spike_count <= '0;
        end else if (clr) begin
            // Detector state is deliberately left alone; a coincident spike is discarded.
            r_isi_cnt     <= '0;
            r_have_prev   <= 1'b0;
            r_spike_pulse <= 1'b0;
            r_overflow    <= 1'b0;
            r_spike_count <= '0;
        end else begin
            r_spike_pulse <= w_spike;
            if (w_drop) r_overflow <= 1'b1;
            if (w_spike) begin
                r_state       <= REFRACT;
                r_isi_cnt     <= '0;
                r_have_prev   <= 1'b1;
                r_spike_count <= CNT_W'(sat_inc(32'(r_spike_count), 32'(CNT_MAX)));
            end else if (sample_en) begin
                r_isi_cnt <= w_isi_next;
                if (w_rearm) r_state <= ARMED;
            end
        end
    end

    assign spike_pulse   = r_spike_pulse;
    assign overflow      = r_overflow;
    assign spike_count   = r_spike_count;
    assign dbg_state     = r_state;
    assign isi.isi_valid = !w_empty;

endmodule

// File: tb/tb_izh_spike_monitor.sv
// Directed bench for izh_spike_monitor: a 16-bit-ISI and a 4-bit-ISI instance
// share all stimulus so saturation can be observed side by side.
module tb_izh_spike_monitor;
    import izh_mon_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              sample_en;
    logic signed [7:0] v_in;
    logic              clr;

    izh_isi_if #(.WIDTH(16)) if16 ();
    izh_isi_if #(.WIDTH(4))  if4 ();

    logic        p16, ovf16, p4, ovf4;
    logic [15:0] cnt16, cnt4;
    det_state_t  st16, st4;

    izh_spike_monitor #(.ISI_W(16)) dut16 (
        .clk (clk), .rst_n (rst_n), .sample_en (sample_en), .v_in (v_in), .clr (clr),
        .spike_pulse (p16), .isi (if16), .overflow (ovf16), .spike_count (cnt16),
        .dbg_state (st16)
    );

    izh_spike_monitor #(.ISI_W(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .sample_en (sample_en), .v_in (v_in), .clr (clr),
        .spike_pulse (p4), .isi (if4), .overflow (ovf4), .spike_count (cnt4),
        .dbg_state (st4)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic pulse, input logic valid,
                              input logic [15:0] d16, input logic [15:0] d4,
                              input logic ovf, input logic [15:0] cnt, input det_state_t st);
        chk({tag, " pulse16"}, 32'(p16), 32'(pulse));
        chk({tag, " valid16"}, 32'(if16.isi_valid), 32'(valid));
        chk({tag, " data16"},  32'(if16.isi_data), 32'(d16));
        chk({tag, " ovf16"},   32'(ovf16), 32'(ovf));
        chk({tag, " cnt16"},   32'(cnt16), 32'(cnt));
        chk({tag, " state16"}, 32'(st16), 32'(st));
        chk({tag, " pulse4"},  32'(p4), 32'(pulse));
        chk({tag, " valid4"},  32'(if4.isi_valid), 32'(valid));
        chk({tag, " data4"},   32'(if4.isi_data), 32'(d4));
        chk({tag, " ovf4"},    32'(ovf4), 32'(ovf));
        chk({tag, " cnt4"},    32'(cnt4), 32'(cnt));
        chk({tag, " state4"},  32'(st4), 32'(st));
    endtask

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next.
    task automatic drive(input logic en, input logic signed [7:0] v, input logic c, input logic rdy);
        sample_en      = en;
        v_in           = v;
        clr            = c;
        if16.isi_ready = rdy;
        if4.isi_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    // gap-1 low samples then one spike sample, ready applied only on the spike sample
    task automatic spike_after(input int gap, input logic rdy);
        for (int i = 0; i < gap - 1; i++) drive(1'b1, -8'sd45, 1'b0, 1'b0);
        drive(1'b1, 8'sd20, 1'b0, rdy);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              en;
        logic signed [7:0] v;
        logic              c;
        logic              rdy;
        logic              pulse;
        logic              valid;
        logic [15:0]       data;
        logic              ovf;
        logic [15:0]       cnt;
        det_state_t        st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic signed [7:0] v, input logic c, input logic rdy,
                       input logic pulse, input logic valid, input logic [15:0] data,
                       input logic ovf, input logic [15:0] cnt, input det_state_t st);
        vec_t r;
        r.en = en; r.v = v; r.c = c; r.rdy = rdy; r.pulse = pulse; r.valid = valid;
        r.data = data; r.ovf = ovf; r.cnt = cnt; r.st = st;
        tbl.push_back(r);
    endtask

    // ---------------- test ----------------
    initial begin
        rst_n = 1'b0;
        sample_en = 1'b0; v_in = 8'sd0; clr = 1'b0;
        if16.isi_ready = 1'b0; if4.isi_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_both("reset", 0, 0, 0, 0, 0, 0, ARMED);

        // quiet input, then spike / re-arm / spike ten samples later
        add(1, -45, 0, 0,  0, 0, 0,  0, 0, ARMED);
        add(1, -45, 0, 0,  0, 0, 0,  0, 0, ARMED);
        add(1, -45, 0, 0,  0, 0, 0,  0, 0, ARMED);
        add(1,  20, 0, 0,  1, 0, 0,  0, 1, REFRACT);
        add(1,  20, 0, 0,  0, 0, 0,  0, 1, REFRACT);
        add(1, -32, 0, 0,  0, 0, 0,  0, 1, ARMED);
        for (int i = 0; i < 7; i++) add(1, -45, 0, 0,  0, 0, 0,  0, 1, ARMED);
        add(1,  20, 0, 0,  1, 1, 10, 0, 2, REFRACT);
        add(0,   0, 0, 1,  0, 0, 0,  0, 2, REFRACT);
        // hysteresis with inclusive boundaries
        add(1, -24, 0, 0,  0, 0, 0,  0, 2, ARMED);
        add(1,  16, 0, 0,  1, 1, 2,  0, 3, REFRACT);
        add(1,   0, 0, 0,  0, 1, 2,  0, 3, REFRACT);
        add(1,  20, 0, 0,  0, 1, 2,  0, 3, REFRACT);
        add(1, -23, 0, 0,  0, 1, 2,  0, 3, REFRACT);
        add(1,  20, 0, 0,  0, 1, 2,  0, 3, REFRACT);
        add(0, -45, 0, 0,  0, 1, 2,  0, 3, REFRACT);
        add(1, -24, 0, 0,  0, 1, 2,  0, 3, ARMED);
        add(1,  15, 0, 0,  0, 1, 2,  0, 3, ARMED);
        add(0,  20, 0, 0,  0, 1, 2,  0, 3, ARMED);
        add(1,  16, 0, 0,  1, 1, 2,  0, 4, REFRACT);
        add(0,   0, 0, 1,  0, 1, 7,  0, 4, REFRACT);
        add(0,   0, 0, 1,  0, 0, 0,  0, 4, REFRACT);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].v, tbl[i].c, tbl[i].rdy);
            check_both($sformatf("vec%0d", i), tbl[i].pulse, tbl[i].valid, tbl[i].data,
                       tbl[i].data, tbl[i].ovf, tbl[i].cnt, tbl[i].st);
        end

        // overflow: six spikes at ISI 5 with the consumer stalled
        drive(0, 0, 1, 0);
        check_both("clr1", 0, 0, 0, 0, 0, 0, REFRACT);
        drive(1, -45, 0, 0);
        for (int i = 0; i < 6; i++) spike_after(5, 0);
        for (int i = 0; i < 4; i++) drive(1, -45, 0, 0);
        check_both("ovf_full", 0, 1, 5, 5, 1, 6, ARMED);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d valid", i), 32'(if16.isi_valid), 32'd1);
            chk($sformatf("drain%0d data", i), 32'(if16.isi_data), 32'd5);
            drive(0, 0, 0, 1);
        end
        check_both("drained", 0, 0, 0, 0, 1, 6, ARMED);

        // full buffer, spike coincident with a pop
        drive(0, 0, 1, 0);
        check_both("clr2", 0, 0, 0, 0, 0, 0, ARMED);
        spike_after(1, 0);
        for (int g = 3; g <= 6; g++) begin
            spike_after(g, 0);
            exp_q.push_back(16'(g));
        end
        chk("full data", 32'(if16.isi_data), 32'(exp_q[0]));
        spike_after(7, 1);
        void'(exp_q.pop_front());
        exp_q.push_back(16'd7);
        check_both("push_pop_full", 1, 1, exp_q[0], exp_q[0], 0, 6, REFRACT);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            chk($sformatf("order%0d data16", i), 32'(if16.isi_data), 32'(exp_q[0]));
            chk($sformatf("order%0d data4", i), 32'(if4.isi_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            drive(0, 0, 0, 1);
        end
        chk("order empty", 32'(if16.isi_valid), 32'd0);

        // ISI saturation in the 4-bit build
        spike_after(20, 0);
        check_both("sat", 1, 1, 20, 15, 0, 7, REFRACT);

        // clr with a coincident spike sample
        drive(1, -45, 0, 0);
        drive(1, 20, 1, 0);
        check_both("clr_spike", 0, 0, 0, 0, 0, 0, ARMED);
        drive(1, 20, 0, 0);
        check_both("first_after_clr", 1, 0, 0, 0, 0, 1, REFRACT);
        spike_after(3, 0);
        check_both("second_after_clr", 1, 1, 3, 3, 0, 2, REFRACT);

        // reset mid-operation
        rst_n = 1'b0;
        drive(1, 20, 0, 0);
        check_both("rst_mid", 0, 0, 0, 0, 0, 0, ARMED);
        rst_n = 1'b1;
        drive(1, 20, 0, 0);
        check_both("after_rst", 1, 0, 0, 0, 0, 1, REFRACT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
